// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product feeder.
// Holds the default geometry of the DotProductSt engine, the feeder FSM
// state encoding and a small helper for sizing counters.
package dp_pkg;

    localparam int DP_PIXEL_N        = 10;
    localparam int DP_PIXEL_SIZE     = 10;
    localparam int DP_WEIGHT_SIZE    = 19;
    localparam int DP_VAL_SIZE       = 26;
    localparam int DP_PARALLEL       = 1;
    localparam int DP_RESULT_LATENCY = 8;
    localparam int DP_ADDR_W         = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } dp_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int dp_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dot_product_feeder_if.sv
// Load port of the dot-product feeder: one pixel/weight pair per cycle.
//   load_en     : write the pair this cycle
//   load_addr   : element index
//   load_pixel  : pixel data
//   load_weight : weight data (opaque fixed-point)
// master drives the port (memory side), slave is the feeder.
interface dot_product_feeder_if #(
    parameter int ADDR_W      = dp_pkg::DP_ADDR_W,
    parameter int PIXEL_SIZE  = dp_pkg::DP_PIXEL_SIZE,
    parameter int WEIGHT_SIZE = dp_pkg::DP_WEIGHT_SIZE
);
    logic                   load_en;
    logic [ADDR_W-1:0]      load_addr;
    logic [PIXEL_SIZE-1:0]  load_pixel;
    logic [WEIGHT_SIZE-1:0] load_weight;

    modport master (
        output load_en,
        output load_addr,
        output load_pixel,
        output load_weight
    );

    modport slave (
        input load_en,
        input load_addr,
        input load_pixel,
        input load_weight
    );
endinterface

// File: rtl/dp_feed_buffer.sv
// Pixel and weight register file for one dot-product vector.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (clears all)
//   wr_en/wr_addr         : write one element; addresses >= PIXEL_N are dropped
//   wr_pixel/wr_weight    : write data
//   rd_beat               : beat index; lane j reads element rd_beat*PARALLEL+j
//   rd_pixels/rd_weights  : PARALLEL lanes packed lane 0 at the LSBs
module dp_feed_buffer
    import dp_pkg::*;
#(
    parameter int PIXEL_N     = DP_PIXEL_N,
    parameter int PIXEL_SIZE  = DP_PIXEL_SIZE,
    parameter int WEIGHT_SIZE = DP_WEIGHT_SIZE,
    parameter int PARALLEL    = DP_PARALLEL,
    parameter int ADDR_W      = DP_ADDR_W,
    parameter int BEAT_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [PIXEL_SIZE-1:0]           wr_pixel,
    input  logic [WEIGHT_SIZE-1:0]          wr_weight,
    input  logic [BEAT_W-1:0]               rd_beat,
    output logic [PARALLEL*PIXEL_SIZE-1:0]  rd_pixels,
    output logic [PARALLEL*WEIGHT_SIZE-1:0] rd_weights
);

    localparam int BEATS = PIXEL_N / PARALLEL;

    logic [PIXEL_SIZE-1:0]  pix_q [PIXEL_N];
    logic [PIXEL_SIZE-1:0]  pix_d [PIXEL_N];
    logic [WEIGHT_SIZE-1:0] wgt_q [PIXEL_N];
    logic [WEIGHT_SIZE-1:0] wgt_d [PIXEL_N];

    // Address compare per entry: out-of-range addresses simply match nothing.
    always_comb begin
        pix_d = pix_q;
        wgt_d = wgt_q;
        for (int i = 0; i < PIXEL_N; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                pix_d[i] = wr_pixel;
                wgt_d[i] = wr_weight;
            end
        end
    end

    always_comb begin
        rd_pixels  = '0;
        rd_weights = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (rd_beat == BEAT_W'(b)) begin
                for (int j = 0; j < PARALLEL; j++) begin
                    rd_pixels[j*PIXEL_SIZE +: PIXEL_SIZE]    = pix_q[b*PARALLEL + j];
                    rd_weights[j*WEIGHT_SIZE +: WEIGHT_SIZE] = wgt_q[b*PARALLEL + j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIXEL_N; i++) begin
                pix_q[i] <= '0;
                wgt_q[i] <= '0;
            end
        end else begin
            pix_q <= pix_d;
            wgt_q <= wgt_d;
        end
    end

endmodule

// File: rtl/dot_product_feeder.sv
// Source-side sequencer for one DotProductSt engine.
// Buffers a vector of pixels/weights, then on start clears the engine,
// streams PARALLEL lanes per beat, waits out the engine pipeline and
// captures the engine value as a registered result with a valid pulse.
// Ports:
//   clk, GlobalReset      : clock, synchronous active-high reset
//   load_bus (slave)      : pixel/weight write port, honoured only in IDLE
//   start                 : begin one dot product (ignored unless IDLE)
//   busy                  : high in CLEAR, STREAM and DRAIN
//   dp_clear              : reset pulse to the engine
//   Pixels/Weights        : engine operands, lane j at slice j
//   value_in              : engine result
//   result/result_valid   : captured dot product and its one-cycle strobe
//
// state  | meaning
// IDLE   | accepting loads and start
// CLEAR  | one cycle of dp_clear, operands zero
// STREAM | BEATS cycles of operands from the buffer
// DRAIN  | RESULT_LATENCY cycles of zero operands while the engine settles
// DONE   | capture value_in, pulse result_valid
module dot_product_feeder
    import dp_pkg::*;
#(
    parameter int PIXEL_N        = DP_PIXEL_N,
    parameter int PIXEL_SIZE     = DP_PIXEL_SIZE,
    parameter int WEIGHT_SIZE    = DP_WEIGHT_SIZE,
    parameter int PARALLEL       = DP_PARALLEL,
    parameter int VAL_SIZE       = DP_VAL_SIZE,
    parameter int RESULT_LATENCY = DP_RESULT_LATENCY,
    parameter int ADDR_W         = DP_ADDR_W
) (
    input  logic                            clk,
    input  logic                            GlobalReset,
    dot_product_feeder_if.slave             load_bus,
    input  logic                            start,
    output logic                            busy,
    output logic                            dp_clear,
    output logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels,
    output logic [PARALLEL*WEIGHT_SIZE-1:0] Weights,
    input  logic [VAL_SIZE-1:0]             value_in,
    output logic [VAL_SIZE-1:0]             result,
    output logic                            result_valid
);

    localparam int BEATS   = PIXEL_N / PARALLEL;
    localparam int BEAT_W  = dp_cnt_w(BEATS);
    localparam int DRAIN_W = dp_cnt_w(RESULT_LATENCY + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        (RESULT_LATENCY > 0) ? DRAIN_W'(RESULT_LATENCY - 1) : '0;

    if (PIXEL_N % PARALLEL != 0) begin : g_bad_parallel
        $error("dot_product_feeder: PIXEL_N must be a multiple of PARALLEL");
    end
    if ((1 << ADDR_W) < PIXEL_N) begin : g_bad_addr_w
        $error("dot_product_feeder: ADDR_W too narrow for PIXEL_N");
    end

    dp_state_e                      state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [DRAIN_W-1:0]             drain_q, drain_d;
    logic                           busy_q, busy_d;
    logic                           dp_clear_q, dp_clear_d;
    logic [PARALLEL*PIXEL_SIZE-1:0]  pixels_q, pixels_d;
    logic [PARALLEL*WEIGHT_SIZE-1:0] weights_q, weights_d;
    logic [VAL_SIZE-1:0]            result_q, result_d;
    logic                           result_valid_q, result_valid_d;

    logic                            buf_wr_en;
    logic [PARALLEL*PIXEL_SIZE-1:0]  buf_pixels;
    logic [PARALLEL*WEIGHT_SIZE-1:0] buf_weights;

    assign buf_wr_en = load_bus.load_en && (state_q == IDLE);

    // Read at the next beat index so the registered operands line up with
    // the beat the FSM is entering.
    dp_feed_buffer #(
        .PIXEL_N     (PIXEL_N),
        .PIXEL_SIZE  (PIXEL_SIZE),
        .WEIGHT_SIZE (WEIGHT_SIZE),
        .PARALLEL    (PARALLEL),
        .ADDR_W      (ADDR_W),
        .BEAT_W      (BEAT_W)
    ) u_buffer (
        .clk        (clk),
        .rst        (GlobalReset),
        .wr_en      (buf_wr_en),
        .wr_addr    (load_bus.load_addr),
        .wr_pixel   (load_bus.load_pixel),
        .wr_weight  (load_bus.load_weight),
        .rd_beat    (beat_d),
        .rd_pixels  (buf_pixels),
        .rd_weights (buf_weights)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    beat_d  = '0;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                beat_d  = '0;
            end
            STREAM: begin
                if (beat_q == LAST_BEAT) begin
                    drain_d = DRAIN_LOAD;
                    state_d = (RESULT_LATENCY == 0) ? DONE : DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
                drain_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they belong to.
        busy_d         = (state_d == CLEAR) || (state_d == STREAM) || (state_d == DRAIN);
        dp_clear_d     = (state_d == CLEAR);
        pixels_d       = (state_d == STREAM) ? buf_pixels  : '0;
        weights_d      = (state_d == STREAM) ? buf_weights : '0;
        result_valid_d = (state_d == DONE);
        result_d       = (state_d == DONE) ? value_in : result_q;
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            dp_clear_q     <= 1'b0;
            pixels_q       <= '0;
            weights_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            drain_q        <= drain_d;
            busy_q         <= busy_d;
            dp_clear_q     <= dp_clear_d;
            pixels_q       <= pixels_d;
            weights_q      <= weights_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign dp_clear     = dp_clear_q;
    assign Pixels       = pixels_q;
    assign Weights      = weights_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: a PARALLEL=1 and a PARALLEL=2 instance share
// one load bus, each drives a behavioural engine stub (accumulator plus
// pipeline delay), and expected results are queued at start and popped on
// result_valid.
module tb_dot_product_feeder;

    localparam int PN = 10;
    localparam int PS = 10;
    localparam int WS = 19;
    localparam int VS = 26;
    localparam int RL = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst, start1, start2;

    logic            busy1, dpc1, rv1;
    logic [PS-1:0]   pix1;
    logic [WS-1:0]   w1;
    logic [VS-1:0]   val1, res1;

    logic            busy2, dpc2, rv2;
    logic [2*PS-1:0] pix2;
    logic [2*WS-1:0] w2;
    logic [VS-1:0]   val2, res2;

    dot_product_feeder_if #(.ADDR_W(AW), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS)) ld1 ();
    dot_product_feeder_if #(.ADDR_W(AW), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS)) ld2 ();

    dot_product_feeder #(
        .PIXEL_N(PN), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .PARALLEL(1),
        .VAL_SIZE(VS), .RESULT_LATENCY(RL), .ADDR_W(AW)
    ) dut1 (
        .clk(clk), .GlobalReset(rst), .load_bus(ld1.slave), .start(start1),
        .busy(busy1), .dp_clear(dpc1), .Pixels(pix1), .Weights(w1),
        .value_in(val1), .result(res1), .result_valid(rv1)
    );

    dot_product_feeder #(
        .PIXEL_N(PN), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .PARALLEL(2),
        .VAL_SIZE(VS), .RESULT_LATENCY(RL), .ADDR_W(AW)
    ) dut2 (
        .clk(clk), .GlobalReset(rst), .load_bus(ld2.slave), .start(start2),
        .busy(busy2), .dp_clear(dpc2), .Pixels(pix2), .Weights(w2),
        .value_in(val2), .result(res2), .result_valid(rv2)
    );

    // Engine stubs: accumulate every cycle, clear on dp_clear, and present
    // the sum RL-1 cycles later so value_in is valid exactly RL cycles after
    // the last beat.
    logic [VS-1:0] acc1, acc2;
    logic [VS-1:0] pipe1 [RL-1];
    logic [VS-1:0] pipe2 [RL-1];

    always @(posedge clk) begin
        if (rst) begin
            acc1 <= '0;
            acc2 <= '0;
            for (int i = 0; i < RL-1; i++) begin
                pipe1[i] <= '0;
                pipe2[i] <= '0;
            end
        end else begin
            acc1 <= dpc1 ? '0 : acc1 + VS'(64'(pix1) * 64'(w1));
            acc2 <= dpc2 ? '0 : acc2 + VS'(64'(pix2[PS-1:0]) * 64'(w2[WS-1:0]))
                                     + VS'(64'(pix2[2*PS-1:PS]) * 64'(w2[2*WS-1:WS]));
            pipe1[0] <= acc1;
            pipe2[0] <= acc2;
            for (int i = 1; i < RL-1; i++) begin
                pipe1[i] <= pipe1[i-1];
                pipe2[i] <= pipe2[i-1];
            end
        end
    end
    assign val1 = pipe1[RL-2];
    assign val2 = pipe2[RL-2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [VS-1:0] val;
        int            at;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic [PS-1:0] pix_m [PN];
    logic [WS-1:0] w_m   [PN];

    function automatic logic [VS-1:0] exp_dot();
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < PN; i++) s += 64'(pix_m[i]) * 64'(w_m[i]);
        return VS'(s);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rv1 === 1'b1) begin
            chk("p1_valid_expected", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("p1_result", 64'(res1), 64'(e.val));
                chk("p1_valid_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (!rst && rv2 === 1'b1) begin
            chk("p2_valid_expected", 64'(q2.size() > 0), 64'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("p2_result", 64'(res2), 64'(e.val));
                chk("p2_valid_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic en, input int a, input logic [PS-1:0] p,
                              input logic [WS-1:0] w);
        ld1.load_en = en;  ld1.load_addr = AW'(a); ld1.load_pixel = p; ld1.load_weight = w;
        ld2.load_en = en;  ld2.load_addr = AW'(a); ld2.load_pixel = p; ld2.load_weight = w;
    endtask

    // Load while idle; the model follows the documented address filter.
    task automatic load_vec(input int a, input logic [PS-1:0] p, input logic [WS-1:0] w);
        step();
        drive_load(1'b1, a, p, w);
        if (a < PN) begin
            pix_m[a] = p;
            w_m[a]   = w;
        end
    endtask

    task automatic push_both(input int s1, input int s2);
        q1.push_back('{val: exp_dot(), at: s1});
        q2.push_back('{val: exp_dot(), at: s2});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [2*PS-1:0] e2;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        drive_load(1'b0, 0, '0, '0);
        for (int i = 0; i < PN; i++) begin
            pix_m[i] = '0;
            w_m[i]   = '0;
        end
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_dpc1", 64'(dpc1), 64'd0);
        chk("rst_pix1", 64'(pix1), 64'd0);
        chk("rst_w1", 64'(w1), 64'd0);
        chk("rst_res1", 64'(res1), 64'd0);
        chk("rst_rv1", 64'(rv1), 64'd0);
        chk("rst_pix2", 64'(pix2), 64'd0);
        chk("rst_res2", 64'(res2), 64'd0);
        step();
        rst = 1'b0;

        // Run 1: pixels 0..9, weights 0x20000, with ignored starts and load.
        for (int i = 0; i < PN; i++) load_vec(i, PS'(i), 19'h20000);
        step();
        drive_load(1'b0, 0, '0, '0);
        start1 = 1'b1; start2 = 1'b1;
        s = cyc;
        push_both(s + 20, s + 15);
        chk("run1_expected_value", 64'(exp_dot()), 64'(45 * 32'h20000));
        for (int c = 1; c <= 21; c++) begin
            step();
            start1 = (c == 3 || c == 10);
            start2 = (c == 3 || c == 10);
            if (c == 4) drive_load(1'b1, 0, 10'h3FF, 19'h7FFFF);
            else        drive_load(1'b0, 0, '0, '0);
            @(negedge clk);
            chk("run1_dpc1", 64'(dpc1), 64'(c == 1));
            chk("run1_dpc2", 64'(dpc2), 64'(c == 1));
            chk("run1_busy1", 64'(busy1), 64'(c <= 19));
            chk("run1_busy2", 64'(busy2), 64'(c <= 14));
            chk("run1_pix1", 64'(pix1), (c >= 2 && c <= 11) ? 64'(pix_m[c-2]) : 64'd0);
            chk("run1_w1", 64'(w1), (c >= 2 && c <= 11) ? 64'(w_m[c-2]) : 64'd0);
            e2 = '0;
            if (c >= 2 && c <= 6) e2 = {pix_m[2*(c-2)+1], pix_m[2*(c-2)]};
            chk("run1_pix2", 64'(pix2), 64'(e2));
        end
        chk("run1_q1_drained", 64'(q1.size()), 64'd0);
        chk("run1_q2_drained", 64'(q2.size()), 64'd0);

        // Run 2: same buffers (element 0 must be untouched), then back-to-back
        // starts issued the cycle after each result_valid.
        step();
        start1 = 1'b1; start2 = 1'b1;
        s = cyc;
        push_both(s + 20, s + 15);
        for (int c = 1; c <= 42; c++) begin
            step();
            start1 = (c == 21);
            start2 = (c == 16);
            if (c == 21) q1.push_back('{val: exp_dot(), at: s + 21 + 20});
            if (c == 16) q2.push_back('{val: exp_dot(), at: s + 16 + 15});
            @(negedge clk);
            if (c == 17) chk("b2b_dpc2", 64'(dpc2), 64'd1);
            if (c == 22) chk("b2b_dpc1", 64'(dpc1), 64'd1);
        end
        chk("run2_q1_drained", 64'(q1.size()), 64'd0);
        chk("run2_q2_drained", 64'(q2.size()), 64'd0);

        // Run 3: reset during STREAM, then a run over cleared buffers.
        step();
        start1 = 1'b1; start2 = 1'b1;
        s = cyc;
        push_both(s + 20, s + 15);
        for (int c = 1; c <= 6; c++) begin
            step();
            start1 = 1'b0; start2 = 1'b0;
            rst = (c == 5);
            if (c == 5) begin
                q1.delete();
                q2.delete();
                for (int i = 0; i < PN; i++) begin
                    pix_m[i] = '0;
                    w_m[i]   = '0;
                end
            end
        end
        @(negedge clk);
        chk("midrst_busy1", 64'(busy1), 64'd0);
        chk("midrst_busy2", 64'(busy2), 64'd0);
        chk("midrst_pix1", 64'(pix1), 64'd0);
        chk("midrst_pix2", 64'(pix2), 64'd0);
        chk("midrst_w1", 64'(w1), 64'd0);
        chk("midrst_rv1", 64'(rv1), 64'd0);
        chk("midrst_res1", 64'(res1), 64'd0);
        step();
        start1 = 1'b1; start2 = 1'b1;
        s = cyc;
        push_both(s + 20, s + 15);
        for (int c = 1; c <= 21; c++) begin
            step();
            start1 = 1'b0; start2 = 1'b0;
        end
        @(negedge clk);
        chk("run3_q1_drained", 64'(q1.size()), 64'd0);
        chk("run3_q2_drained", 64'(q2.size()), 64'd0);

        // Run 4: reload, plus an out-of-range write that must be dropped.
        for (int i = 0; i < PN; i++) load_vec(i, PS'(i), 19'h20000);
        load_vec(12, 10'h3FF, 19'h7FFFF);
        step();
        drive_load(1'b0, 0, '0, '0);
        start1 = 1'b1; start2 = 1'b1;
        s = cyc;
        push_both(s + 20, s + 15);
        for (int c = 1; c <= 21; c++) begin
            step();
            start1 = 1'b0; start2 = 1'b0;
        end
        @(negedge clk);
        chk("run4_q1_drained", 64'(q1.size()), 64'd0);
        chk("run4_q2_drained", 64'(q2.size()), 64'd0);
        chk("run4_res1_hold", 64'(res1), 64'(45 * 32'h20000));
        chk("run4_res2_hold", 64'(res2), 64'(45 * 32'h20000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
